// File: rtl/neuron_mac.sv
// Signed fixed-point multiply-accumulate neuron stage feeding the ReLU stage.
// Optional build macro NEURON_MAC_SAT_EN clips the rounded result to D_WIDTH and raises sat.
module neuron_mac #(
  parameter int D_WIDTH   = 16,
  parameter int FRAC_BITS = 8,
  parameter int ACC_WIDTH = 40
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic signed [D_WIDTH-1:0] bias_in,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_last,
  input  logic signed [D_WIDTH-1:0] data_in,
  input  logic signed [D_WIDTH-1:0] weight_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [D_WIDTH-1:0] data_out,
  output logic                      sat,
  output logic                      busy
);

  typedef enum logic [1:0] {IDLE, ACC, ROUND, OUT} state_t;

  localparam logic signed [ACC_WIDTH-1:0] R_MAX =
    {{(ACC_WIDTH-D_WIDTH+1){1'b0}}, {(D_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] R_MIN =
    {{(ACC_WIDTH-D_WIDTH+1){1'b1}}, {(D_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_WIDTH-1:0] HALF_LSB =
    {{(ACC_WIDTH-1){1'b0}}, 1'b1} <<< (FRAC_BITS-1);

  state_t                        state, state_nxt;
  logic signed [ACC_WIDTH-1:0]   acc;
  logic signed [2*D_WIDTH-1:0]   prod;
  logic signed [ACC_WIDTH-1:0]   prod_ext;
  logic signed [ACC_WIDTH-1:0]   bias_ext;
  logic signed [ACC_WIDTH-1:0]   rounded;
  logic        [D_WIDTH:0]       narrowed;

  // Round half toward +inf, then drop the fractional bits arithmetically.
  function automatic logic signed [ACC_WIDTH-1:0] round_half_up(
    input logic signed [ACC_WIDTH-1:0] a
  );
    logic signed [ACC_WIDTH-1:0] t;
    t = a + HALF_LSB;
    return t >>> FRAC_BITS;
  endfunction

  // Returns {sat_flag, value} for the rounded accumulator.
  function automatic logic [D_WIDTH:0] narrow(input logic signed [ACC_WIDTH-1:0] r);
`ifdef NEURON_MAC_SAT_EN
    if (r > R_MAX)      return {1'b1, R_MAX[D_WIDTH-1:0]};
    else if (r < R_MIN) return {1'b1, R_MIN[D_WIDTH-1:0]};
    else                return {1'b0, r[D_WIDTH-1:0]};
`else
    return {1'b0, r[D_WIDTH-1:0]};
`endif
  endfunction

  assign prod     = data_in * weight_in;
  assign prod_ext = {{(ACC_WIDTH-2*D_WIDTH){prod[2*D_WIDTH-1]}}, prod};
  assign bias_ext = {{(ACC_WIDTH-D_WIDTH){bias_in[D_WIDTH-1]}}, bias_in} <<< FRAC_BITS;
  assign rounded  = round_half_up(acc);
  assign narrowed = narrow(rounded);

  assign in_ready = (state == ACC);
  assign busy     = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)               state_nxt = ACC;
      ACC:     if (in_valid && in_last) state_nxt = ROUND;
      ROUND:                            state_nxt = OUT;
      OUT:     if (out_ready)           state_nxt = IDLE;
      default:                          state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      acc       <= '0;
      data_out  <= '0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE:  if (start) acc <= bias_ext;
        ACC:   if (in_valid) acc <= acc + prod_ext;
        // Result registers are written once per neuron and held through OUT.
        ROUND: begin
          data_out  <= narrowed[D_WIDTH-1:0];
          sat       <= narrowed[D_WIDTH];
          out_valid <= 1'b1;
        end
        OUT:   if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac.sv
// Scoreboard bench for neuron_mac: directed neurons push expected results, a monitor checks them.
module tb_neuron_mac;

  localparam int D_WIDTH   = 16;
  localparam int FRAC_BITS = 8;
  localparam int ACC_WIDTH = 40;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic out_ready = 1'b1;
  logic signed [D_WIDTH-1:0] bias_in = '0;
  logic signed [D_WIDTH-1:0] data_in = '0;
  logic signed [D_WIDTH-1:0] weight_in = '0;
  logic in_ready, out_valid, sat, busy;
  logic signed [D_WIDTH-1:0] data_out;

  neuron_mac #(.D_WIDTH(D_WIDTH), .FRAC_BITS(FRAC_BITS), .ACC_WIDTH(ACC_WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .bias_in(bias_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .data_in(data_in), .weight_in(weight_in),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
    .sat(sat), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [15:0] data;
    logic        sat;
  } exp_t;

  exp_t   sb_q[$];
  int     n_cmp = 0;
  int     n_bad = 0;
  longint m_acc;
  string  cur_tag;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: round half up on the exact sum, then clip or wrap to 16 bits.
  function automatic exp_t model_out(input string tag, input longint a);
    exp_t   e;
    longint r;
    r = (a + (longint'(1) <<< (FRAC_BITS-1))) >>> FRAC_BITS;
    e.tag = tag;
`ifdef NEURON_MAC_SAT_EN
    if (r > 32767)       begin e.data = 16'h7FFF; e.sat = 1'b1; end
    else if (r < -32768) begin e.data = 16'h8000; e.sat = 1'b1; end
    else                 begin e.data = r[15:0];  e.sat = 1'b0; end
`else
    e.data = r[15:0];
    e.sat  = 1'b0;
`endif
    return e;
  endfunction

  task automatic begin_neuron(input string tag, input logic signed [15:0] b);
    cur_tag = tag;
    m_acc   = longint'(b) <<< FRAC_BITS;
    start   = 1'b1;
    bias_in = b;
    @(posedge clk); #1;
    start   = 1'b0;
  endtask

  task automatic beat(input logic signed [15:0] d, input logic signed [15:0] w,
                      input logic last, input int gap);
    data_in   = d;
    weight_in = w;
    in_valid  = 1'b1;
    in_last   = last;
    m_acc    += longint'(d) * longint'(w);
    if (last) sb_q.push_back(model_out(cur_tag, m_acc));
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 30) begin @(posedge clk); #1; n++; end
    check({"idle_", cur_tag}, 16'(busy), 16'd0);
  endtask

  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      exp_t e;
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_unexpected actual=%h required=none", data_out);
      end else begin
        e = sb_q.pop_front();
        check({e.tag, "_data"}, data_out, e.data);
        check({e.tag, "_sat"}, 16'(sat), 16'(e.sat));
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 16'(out_valid), 16'd0);
    check("rst_data_out",  data_out,       16'h0000);
    check("rst_sat",       16'(sat),       16'd0);
    check("rst_busy",      16'(busy),      16'd0);
    check("rst_in_ready",  16'(in_ready),  16'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // 0.5 + 2.0*1.5 = 3.5, with first-result latency checks
    begin_neuron("basic", 16'sh0080);
    check("acc_in_ready", 16'(in_ready), 16'd1);
    beat(16'sh0200, 16'sh0180, 1'b1, 0);
    check("round_out_valid", 16'(out_valid), 16'd0);
    check("round_in_ready",  16'(in_ready),  16'd0);
    @(posedge clk); #1;
    check("lat_out_valid", 16'(out_valid), 16'd1);
    check("lat_data_out",  data_out,       16'h0380);
    wait_idle();

    begin_neuron("neg", 16'sh0000);
    beat(16'shFF00, 16'sh0200, 1'b1, 0);
    wait_idle();

    begin_neuron("gapped", 16'sh0000);
    for (int i = 0; i < 4; i++) beat(16'sh0100, 16'sh0100, (i == 3), (i < 3) ? 1 : 0);
    wait_idle();

    begin_neuron("rnd_up", 16'sh0000);
    beat(16'sh0001, 16'sh0080, 1'b1, 0);
    wait_idle();

    begin_neuron("rnd_half_neg", 16'sh0000);
    beat(16'shFFFF, 16'sh0080, 1'b1, 0);
    wait_idle();

    begin_neuron("sat_pos", 16'sh0000);
    beat(16'sh7F00, 16'sh7F00, 1'b1, 0);
    wait_idle();

    begin_neuron("sat_neg", 16'sh0000);
    beat(16'sh8000, 16'sh7FFF, 1'b1, 0);
    wait_idle();

    // -0.5 + 1.5*1.0 + (-1.5*0.25) = 0.625
    begin_neuron("mixed", 16'shFF80);
    beat(16'sh0180, 16'sh0100, 1'b0, 0);
    beat(16'shFE80, 16'sh0040, 1'b1, 0);
    wait_idle();

    // Backpressure: 1.0 + 3.0*1.0 = 4.0 held while out_ready is low
    out_ready = 1'b0;
    begin_neuron("bp", 16'sh0100);
    beat(16'sh0300, 16'sh0100, 1'b1, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      start = 1'b1;
      check("bp_out_valid", 16'(out_valid), 16'd1);
      check("bp_data_out",  data_out,       16'h0400);
      check("bp_in_ready",  16'(in_ready),  16'd0);
      check("bp_busy",      16'(busy),      16'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("bp_release_busy",      16'(busy),      16'd0);
    check("bp_release_out_valid", 16'(out_valid), 16'd0);
    @(posedge clk); #1;
    check("bp_start_ignored", 16'(busy), 16'd0);

    // Reset in the middle of accumulation discards the partial sum
    begin_neuron("rst_mid", 16'sh0100);
    for (int i = 0; i < 3; i++) beat(16'sh0200, 16'sh0200, 1'b0, 0);
    rst = 1'b0;
    #1;
    check("rst_mid_out_valid", 16'(out_valid), 16'd0);
    check("rst_mid_busy",      16'(busy),      16'd0);
    check("rst_mid_in_ready",  16'(in_ready),  16'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    begin_neuron("post_rst", 16'sh0000);
    beat(16'sh0100, 16'sh0100, 1'b1, 0);
    wait_idle();

    repeat (3) @(posedge clk);
    #1;
    check("sb_drain", 16'(sb_q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
